// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// sync_fifo_pkg : shared defaults and sizing helper for the synchronous FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// sync_fifo_mem : simple dual-port storage, synchronous write and registered read
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) begin
      rd_data_d = mem_q[i_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy count, status flags, error pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_TH);

  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          rd_valid_d, rd_valid_q;
  logic          overflow_d, overflow_q;
  logic          underflow_d, underflow_q;

  logic w_full;
  logic w_empty;
  logic w_rd_accept;
  logic w_wr_accept;

  assign w_full  = (count_q == FULL_CNT);
  assign w_empty = (count_q == '0);

  // A read frees a slot on the same edge, so a full FIFO can still take a write.
  assign w_rd_accept = rd_en & ~w_empty;
  assign w_wr_accept = wr_en & (~w_full | w_rd_accept);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = w_rd_accept;
    overflow_d  = wr_en & w_full & ~w_rd_accept;
    underflow_d = rd_en & w_empty;

    if (w_wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({w_wr_accept, w_rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_accept & ~rst),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_accept),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (data_out)
  );

  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);

endmodule

`default_nettype wire
